deserializer: RTL and testbench
===============================

# deserializer

Serial-to-parallel converter that reassembles MSB-first bit streams into 16-bit words. It sits at the receive end of the serial link driven by the team's serializer (ser_data / ser_data_val pair). It emits one registered word strobe per completed word. An optional idle-timeout flush recovers short words, reported with the same 4-bit mod encoding the serializer uses on its input: 0 means 16 bits, 3..15 means that many bits.

## Interface
- TIMEOUT, 8: consecutive idle cycles (ser_data_val_i low) with a partial word pending before a flush; legal range 1..255. Used only with DESERIALIZER_TIMEOUT_EN.
- clk_i  input  1  clock; all logic on rising edge.
- srst_i  input  1  reset; synchronous, active-high.
- ser_data_i  input  1  serial data bit; MSB of the word arrives first.
- ser_data_val_i  input  1  ser_data_i is valid this cycle; each high cycle delivers exactly one bit.
- deser_data_o  output  16  assembled word; first received bit is in bit [15].
- deser_data_mod_o  output  4  number of valid bits in deser_data_o; 0 = all 16.
- deser_data_val_o  output  1  one-cycle strobe; deser_data_o and deser_data_mod_o are valid.

## Operation
- State:
  - 16-bit shift register shreg.
  - 5-bit bit counter cnt (0..16).
  - 8-bit idle counter (timeout build only).
- Bit accept: when ser_data_val_i=1:
  - shreg <= {shreg[14:0], ser_data_i}.
  - cnt <= cnt+1.
- Word complete: when a bit is accepted and cnt==15:
  - Next cycle: deser_data_o = {shreg[14:0], ser_data_i}, deser_data_mod_o=0, deser_data_val_o=1.
  - cnt returns to 0 in the same edge. It never holds 16 across cycles.
- No input backpressure. The block accepts a bit on every valid cycle, including back-to-back words with no gap.
- deser_data_o and deser_data_mod_o hold their last value between strobes.
- deser_data_val_o is high for exactly one cycle per word.
- ser_data_i is ignored when ser_data_val_i=0.
- Reset values:
  - All outputs 0: deser_data_o=16'h0000, deser_data_mod_o=4'h0, deser_data_val_o=0.
  - shreg, cnt and the idle counter are 0.
- Reset mid-word discards the pending bits. No strobe is emitted for them.
- Reset has priority over a bit presented in the same cycle.

## Timing
- Latency: the strobe asserts the cycle after the 16th accepted bit (1 cycle, registered).
- Back-to-back traffic:
  - The 16th bit of word N is accepted at cycle t; the 1st bit of word N+1 is accepted at cycle t+1.
  - The word N strobe at t+1 coincides with that bit. Both are handled with no bubble.
  - Sustained throughput is 1 word per 16 cycles.
- Gaps in ser_data_val_i within a word are allowed. Bits accumulate across gaps with no limit unless the timeout build is used.
- Maximum strobe rate: one per 16 valid cycles. In the timeout build, one per TIMEOUT+1 cycles for flushes.

## Configuration
- Macro: DESERIALIZER_TIMEOUT_EN.
- Defined (timeout flush built in):
  - The idle counter increments each cycle with ser_data_val_i=0 and 1<=cnt<=15.
  - It clears on any accepted bit, and whenever cnt==0.
  - Flush trigger: the cycle in which the idle counter reaches TIMEOUT, i.e. TIMEOUT consecutive idle cycles.
  - On the next edge the block outputs the partial word:
    - deser_data_o = shreg << (16-cnt), left-aligned, low bits zero.
    - deser_data_mod_o = cnt[3:0].
    - deser_data_val_o = 1.
  - The flush also clears cnt, shreg and the idle counter.
  - A valid bit in the cycle the counter would reach TIMEOUT is accepted normally. No flush occurs and the idle counter clears.
  - Partial words of 1 or 2 bits are flushed as 1 or 2; the mod field is not restricted.
- Undefined:
  - No idle counter is built. Partial words wait indefinitely for more bits.
  - deser_data_mod_o is tied to 0.
  - The TIMEOUT parameter is unused.

## Test plan
- Single word:
  - Stimulus: 16 consecutive valid bits encoding 16'hA5C3, MSB first.
  - Required: deser_data_val_o=1 for exactly one cycle, 1 cycle after the last bit; deser_data_o=16'hA5C3, deser_data_mod_o=0.
- Back-to-back words:
  - Stimulus: 32 consecutive valid bits encoding 16'h1234 then 16'hFFFE.
  - Required: two strobes exactly 16 cycles apart, carrying 16'h1234 then 16'hFFFE; no lost or duplicated bits.
- Gapped input:
  - Stimulus: 16'h8001 sent with random 0..5-cycle gaps between bits (timeout build with TIMEOUT=8, or non-timeout build).
  - Required: a single strobe with 16'h8001.
- Reset mid-word:
  - Stimulus: 7 bits, then srst_i for 1 cycle, then 16 bits of 16'h00FF.
  - Required: no strobe for the 7 bits; one strobe of 16'h00FF; all outputs 0 during and immediately after reset.
- Timeout flush (DESERIALIZER_TIMEOUT_EN, TIMEOUT=8):
  - Stimulus: 5 bits 1,0,1,1,0, then idle.
  - Required: a strobe on the cycle after the 8th idle cycle, with deser_data_o=16'hB000 and deser_data_mod_o=5.
  - Variant: a bit arriving on idle cycle 8 suppresses the flush.
- No timeout (macro undefined):
  - Stimulus: 5 bits, 100 idle cycles, 11 more bits.
  - Required: a single strobe with the combined 16-bit word; deser_data_mod_o=0 throughout.

Source files
------------

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
//   Reassembles MSB-first serial bit streams into 16-bit words. One registered
//   strobe is emitted per completed word. Bits are accepted on every cycle with
//   ser_data_val_i high; there is no backpressure.
//
//   Optional build macro DESERIALIZER_TIMEOUT_EN adds an idle-timeout flush.
//   After TIMEOUT consecutive idle cycles with a partial word pending, that
//   word is emitted left-aligned with its bit count on deser_data_mod_o
//   (0 = 16 bits). Without the macro, partial words wait indefinitely and
//   deser_data_mod_o is tied to 0.
//
// Parameters
//   TIMEOUT           idle cycles before a flush (1..255), timeout build only
// Ports
//   clk_i             clock, rising edge
//   srst_i            synchronous active-high reset
//   ser_data_i        serial data bit, MSB of the word first
//   ser_data_val_i    ser_data_i valid this cycle
//   deser_data_o      assembled word, first received bit in [15]
//   deser_data_mod_o  valid bit count of deser_data_o, 0 = all 16
//   deser_data_val_o  one-cycle strobe qualifying deser_data_o/_mod_o
// -----------------------------------------------------------------------------
module deserializer #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        ser_data_i,
  input  logic        ser_data_val_i,
  output logic [15:0] deser_data_o,
  output logic [3:0]  deser_data_mod_o,
  output logic        deser_data_val_o
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("deserializer: TIMEOUT must be in 1..255");
  end

  logic [15:0] shreg;
  logic [4:0]  cnt;
  logic [15:0] shreg_nxt;
  logic        word_done;
  logic        flush;

  assign shreg_nxt = {shreg[14:0], ser_data_i};
  assign word_done = ser_data_val_i && (cnt == 5'd15);

`ifdef DESERIALIZER_TIMEOUT_EN
  logic [7:0] idle;

  // Flush fires in the idle cycle whose increment would reach TIMEOUT.
  assign flush = !ser_data_val_i && (cnt != 5'd0) && (idle == 8'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (srst_i)
      idle <= 8'd0;
    else if (ser_data_val_i || cnt == 5'd0 || flush)
      idle <= 8'd0;
    else
      idle <= idle + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i)
      deser_data_mod_o <= 4'h0;
    else if (word_done)
      deser_data_mod_o <= 4'h0;
    else if (flush)
      deser_data_mod_o <= cnt[3:0];
  end
`else
  assign flush            = 1'b0;
  assign deser_data_mod_o = 4'h0;
`endif

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      shreg            <= 16'h0000;
      cnt              <= 5'd0;
      deser_data_o     <= 16'h0000;
      deser_data_val_o <= 1'b0;
    end else begin
      deser_data_val_o <= 1'b0;
      if (ser_data_val_i) begin
        shreg <= shreg_nxt;
        if (word_done) begin
          // Counter wraps in the same edge so the next word's first bit
          // can arrive in the very next cycle.
          cnt              <= 5'd0;
          deser_data_o     <= shreg_nxt;
          deser_data_val_o <= 1'b1;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end else if (flush) begin
        // Partial bits sit right-aligned in shreg; shift them to the top.
        deser_data_o     <= shreg << (5'd16 - cnt);
        deser_data_val_o <= 1'b1;
        cnt              <= 5'd0;
        shreg            <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// -----------------------------------------------------------------------------
// tb_deserializer
//   Randomized and directed stimulus for deserializer. The driver keeps a
//   bit-list reference model and pushes each expected strobe (word, mod,
//   cycle) into a scoreboard queue; an independent monitor on the falling
//   edge pops and compares whenever the DUT strobes, flags missing strobes
//   when the expected cycle passes, and checks held outputs between strobes.
// -----------------------------------------------------------------------------
module tb_deserializer;
  localparam int TIMEOUT = 8;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mod;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        srst = 1'b0;
  logic        sdata = 1'b0;
  logic        sval = 1'b0;
  logic [15:0] ddata;
  logic [3:0]  dmod;
  logic        dval;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   rst_exp = -1;
  bit   armed = 0;
  exp_t sb[$];
  bit   pend[$];
  int   idle_run = 0;
  logic [15:0] last_data = 16'h0;
  logic [3:0]  last_mod = 4'h0;

  deserializer #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .srst_i(srst), .ser_data_i(sdata), .ser_data_val_i(sval),
    .deser_data_o(ddata), .deser_data_mod_o(dmod), .deser_data_val_o(dval)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected word from the pending bit list: first bit lands in [15].
  function automatic exp_t make_exp(input int at);
    exp_t e;
    e.data = 16'h0;
    for (int i = 0; i < pend.size(); i++) e.data[15-i] = pend[i];
    e.mod = (pend.size() == 16) ? 4'd0 : 4'(pend.size());
    e.cyc = at;
    return e;
  endfunction

  task automatic step(input logic v, input logic d, input logic r);
    @(posedge clk); #1;
    srst = r; sval = v; sdata = v ? d : logic'($urandom_range(0, 1));
    if (r) begin
      pend.delete(); idle_run = 0; rst_exp = cyc + 1;
    end else if (v) begin
      pend.push_back(d); idle_run = 0;
      if (pend.size() == 16) begin sb.push_back(make_exp(cyc + 1)); pend.delete(); end
    end else begin
`ifdef DESERIALIZER_TIMEOUT_EN
      if (pend.size() > 0) begin
        idle_run++;
        if (idle_run == TIMEOUT) begin
          sb.push_back(make_exp(cyc + 1)); pend.delete(); idle_run = 0;
        end
      end
`endif
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int maxgap);
    for (int i = 15; i >= 0; i--) begin
      step(1'b1, w[i], 1'b0);
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (cyc == rst_exp) begin
      tests++;
      if (ddata !== 16'h0 || dmod !== 4'h0 || dval !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs cyc=%0d got data=%h mod=%h val=%b want 0000/0/0",
                 cyc, ddata, dmod, dval);
      end
      last_data = 16'h0; last_mod = 4'h0; armed = 1;
      // A strobe scheduled into a reset cycle cannot happen.
      while (sb.size() > 0 && sb[0].cyc <= cyc) void'(sb.pop_front());
    end else if (armed) begin
      if (dval === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe cyc=%0d got data=%h mod=%h want none", cyc, ddata, dmod);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (ddata !== e.data || dmod !== e.mod || e.cyc != cyc) begin
            fails++;
            $display("FAIL strobe cyc=%0d got data=%h mod=%0d want data=%h mod=%0d at cyc=%0d",
                     cyc, ddata, dmod, e.data, e.mod, e.cyc);
          end
          last_data = e.data; last_mod = e.mod;
        end
      end else begin
        tests++;
        if (dval !== 1'b0 || ddata !== last_data || dmod !== last_mod) begin
          fails++;
          $display("FAIL hold cyc=%0d got data=%h mod=%h val=%b want data=%h mod=%h val=0",
                   cyc, ddata, dmod, dval, last_data, last_mod);
        end
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          tests++; fails++;
          $display("FAIL missing_strobe cyc=%0d got val=0 want data=%h mod=%0d",
                   cyc, sb[0].data, sb[0].mod);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Single word
    send_word(16'hA5C3, 0);
    idle(3);
    // Back-to-back words, then a random burst of four more
    send_word(16'h1234, 0);
    send_word(16'hFFFE, 0);
    for (int i = 0; i < 4; i++) send_word(16'($urandom), 0);
    idle(3);
    // Gapped input, gaps below TIMEOUT
    send_word(16'h8001, 5);
    idle(3);
    // Reset mid-word
    for (int i = 0; i < 7; i++) step(1'b1, logic'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b0, 1'b1);
    send_word(16'h00FF, 0);
    idle(3);

`ifdef DESERIALIZER_TIMEOUT_EN
    // Timeout flush of 1,0,1,1,0 -> B000 mod 5
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
    idle(TIMEOUT + 4);
    // Bit on idle cycle TIMEOUT suppresses the flush; later 6-bit flush
    for (int i = 0; i < 5; i++) step(1'b1, logic'($urandom_range(0, 1)), 1'b0);
    idle(TIMEOUT - 1);
    step(1'b1, 1'b1, 1'b0);
    idle(TIMEOUT + 2);
    // One- and two-bit flushes
    step(1'b1, 1'b1, 1'b0);
    idle(TIMEOUT + 1);
    step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
    idle(TIMEOUT + 1);
`else
    // Long idle mid-word: no flush, word completes later
    for (int i = 0; i < 5; i++) step(1'b1, logic'($urandom_range(0, 1)), 1'b0);
    idle(100);
    for (int i = 0; i < 11; i++) step(1'b1, logic'($urandom_range(0, 1)), 1'b0);
    idle(3);
`endif

    // Random traffic with occasional long idle runs and rare resets
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70)      step(1'b1, logic'($urandom_range(0, 1)), 1'b0);
      else if (r < 95) step(1'b0, 1'b0, 1'b0);
      else if (r < 99) idle($urandom_range(TIMEOUT - 2, TIMEOUT + 2));
      else             step(1'b0, 1'b0, 1'b1);
    end
    idle(TIMEOUT + 5);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d outstanding strobes want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
